// File: rtl/ball_motion_pkg.sv
// Shared definitions for the falling-ball game: screen geometry, the motion state set and the LFSR.
// Scoring and display stages import this so that every stage agrees on the catch row and the spawn sequence.
package ball_motion_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int CATCH_ROW = 455;

  localparam logic [9:0] X_RESET = 10'd320;

  // x^10 + x^7 + 1: feedback from stages 10 and 7 of the shift register.
  localparam logic [9:0] LFSR_SEED   = 10'h2A5;
  localparam int         LFSR_TAP_HI = 9;
  localparam int         LFSR_TAP_LO = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_FALL,
    S_DECIDE,
    S_HOLD,
    S_FROZEN
  } ball_state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } ball_pos_t;

  function automatic logic [9:0] lfsr_next(input logic [9:0] q);
    return {q[8:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
  endfunction

  // One frame of descent. The sum is one bit wider than Y so a large step cannot wrap past the catch row.
  function automatic logic [9:0] fall_step(input logic [9:0] y, input logic [3:0] spd,
                                           input logic [9:0] limit);
    logic [10:0] sum;
    sum = {1'b0, y} + {7'b0, spd};
    return (sum >= {1'b0, limit}) ? limit : sum[9:0];
  endfunction

endpackage

// File: rtl/ball_motion_if.sv
// Control and position bundle between the ball motion block and the game stages around it.
// The master side drives the frame strobe and game events; the slave side returns the ball state.
interface ball_motion_if;

  logic       frame_tick;
  logic       new_game;
  logic       respawn;
  logic       caught;
  logic       win;
  logic [9:0] Xball;
  logic [9:0] Yball;
  logic       ball_active;
  logic [3:0] speed;

  modport master (
    output frame_tick, new_game, respawn, caught, win,
    input  Xball, Yball, ball_active, speed
  );

  modport slave (
    input  frame_tick, new_game, respawn, caught, win,
    output Xball, Yball, ball_active, speed
  );

endinterface

// File: rtl/lfsr10.sv
// Free-running 10-bit Fibonacci LFSR used to pick spawn columns.
// Seeded non-zero and maximal-length, so it never reaches the all-zero lock-up state.
module lfsr10
  import ball_motion_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] q
);

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Ball motion engine: spawns the ball at a pseudo-random column, drops it one step per frame,
// reports a single catch-row cycle per descent, and adapts fall speed to the catch history.
module ball_motion
  import ball_motion_pkg::*;
#(
  parameter int RADIUS      = 10,
  parameter int SPAWN_Y     = 20,
  parameter int CATCH_Y     = CATCH_ROW,
  parameter int X_BASE      = 64,
  parameter int HOLD_FRAMES = 30,
  parameter int SPEEDUP     = 4,
  parameter int MAX_SPEED   = 8
) (
  input logic          clk,
  input logic          rst_n,
  ball_motion_if.slave bus
);

  localparam int         CATCH_W   = $clog2(SPEEDUP + 1);
  localparam int         FRAME_W   = $clog2(HOLD_FRAMES + 1);
  localparam logic [9:0] CATCH_Y_V = 10'(CATCH_Y);
  localparam logic [9:0] SPAWN_Y_V = 10'(SPAWN_Y);
  localparam logic [9:0] X_BASE_V  = 10'(X_BASE);
  localparam logic [3:0] MAX_SPD_V = 4'(MAX_SPEED);

  // The whole ball, radius included, must stay on screen over the full spawn and fall range.
  if (X_BASE < RADIUS || X_BASE + 511 + RADIUS >= SCREEN_W) begin : g_bad_x_range
    $error("ball_motion: spawn column range leaves the screen");
  end
  if (SPAWN_Y < RADIUS || CATCH_Y + RADIUS >= SCREEN_H || MAX_SPEED > 15) begin : g_bad_y_range
    $error("ball_motion: vertical range or speed limit out of bounds");
  end

  logic [1:0]         rst_sync;
  logic               rst_core_n;
  logic [9:0]         lfsr_q;
  logic               unused_lfsr_msb;
  ball_state_t        state;
  ball_pos_t          pos;
  logic               active_q;
  logic [3:0]         speed_q;
  logic [CATCH_W-1:0] catch_cnt;
  logic [FRAME_W-1:0] frame_cnt;
  logic [9:0]         y_next;

  // NOTE: reset asserts immediately but releases two clocks later, so no flop leaves reset
  // on an edge that races the external deassertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_core_n = rst_sync[1];

  lfsr10 u_lfsr (
    .clk   (clk),
    .rst_n (rst_core_n),
    .q     (lfsr_q)
  );

  // Spawn columns only need 9 random bits.
  assign unused_lfsr_msb = lfsr_q[9];

  assign y_next = fall_step(pos.y, speed_q, CATCH_Y_V);

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state     <= S_IDLE;
      pos.x     <= X_RESET;
      pos.y     <= '0;
      active_q  <= 1'b0;
      speed_q   <= 4'd1;
      catch_cnt <= '0;
      frame_cnt <= '0;
    end else if (bus.win && state != S_IDLE) begin
      // Freeze in place: position is kept so the final frame stays on screen.
      state    <= S_FROZEN;
      active_q <= 1'b0;
    end else if (bus.new_game && (state == S_IDLE || state == S_FALL ||
                                  state == S_HOLD || state == S_FROZEN)) begin
      state     <= S_SPAWN;
      active_q  <= 1'b0;
      speed_q   <= 4'd1;
      catch_cnt <= '0;
    end else begin
      case (state)
        S_SPAWN: begin
          pos.x    <= X_BASE_V + {1'b0, lfsr_q[8:0]};
          pos.y    <= SPAWN_Y_V;
          active_q <= 1'b1;
          state    <= S_FALL;
        end
        S_FALL: begin
          if (bus.frame_tick) begin
            pos.y <= y_next;
            if (y_next == CATCH_Y_V) begin
              state <= S_DECIDE;
            end
          end
        end
        S_DECIDE: begin
          // The catch row is visible for this single cycle, then the ball parks off the play field.
          pos.y     <= '0;
          active_q  <= 1'b0;
          frame_cnt <= '0;
          state     <= S_HOLD;
          if (bus.caught) begin
            if (catch_cnt == CATCH_W'(SPEEDUP - 1)) begin
              catch_cnt <= '0;
              if (speed_q != MAX_SPD_V) begin
                speed_q <= speed_q + 4'd1;
              end
            end else begin
              catch_cnt <= catch_cnt + CATCH_W'(1);
            end
          end else if (bus.respawn) begin
            speed_q   <= 4'd1;
            catch_cnt <= '0;
          end
        end
        S_HOLD: begin
          if (bus.frame_tick) begin
            if (frame_cnt == FRAME_W'(HOLD_FRAMES - 1)) begin
              frame_cnt <= '0;
              state     <= S_SPAWN;
            end else begin
              frame_cnt <= frame_cnt + FRAME_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Xball       = pos.x;
  assign bus.Yball       = pos.y;
  assign bus.ball_active = active_q;
  assign bus.speed       = speed_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: reset, spawn, descent timing, speed adaptation, freeze and restart.
// Spawn columns are predicted from an independent model of the seeded x^10+x^7+1 LFSR.
module tb_ball_motion;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  int         exp_y;
  int         exp_speed;
  int         exp_cnt;
  logic [9:0] exp_x;

  logic [1:0] m_sync;
  logic [9:0] m_q;
  logic [9:0] m_q_prev;

  ball_motion_if bus ();

  ball_motion u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference spawn-column generator: starts from the seed, steps once per clock after
  // reset release plus two synchroniser clocks, shifting left with feedback q[9]^q[6].
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sync   <= 2'b00;
      m_q      <= 10'h2A5;
      m_q_prev <= 10'h2A5;
    end else begin
      m_sync <= {m_sync[0], 1'b1};
      if (m_sync[1]) begin
        m_q_prev <= m_q;
        m_q      <= {m_q[8:0], m_q[9] ^ m_q[6]};
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic pulse_new_game();
    @(negedge clk);
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
  endtask

  // Column the DUT should have loaded on the SPAWN->FALL edge just passed.
  task automatic predict_spawn_x();
    exp_x = 10'd64 + {1'b0, m_q_prev[8:0]};
  endtask

  task automatic fall_tick();
    exp_y = (exp_y + exp_speed > 455) ? 455 : exp_y + exp_speed;
    tick();
    checks++;
    if (bus.Yball !== 10'(exp_y) || bus.ball_active !== 1'b1)
      begin errors++; $display("FAIL fall_step: got y=%0d act=%0b want y=%0d act=1", bus.Yball, bus.ball_active, exp_y); end
  endtask

  // Entered with the DUT in DECIDE and caught/respawn already driven to c/r.
  task automatic finish_descent(input logic c, input logic r);
    if (c) begin
      if (exp_cnt == 3) begin
        exp_cnt = 0;
        if (exp_speed < 8) exp_speed++;
      end else begin
        exp_cnt++;
      end
    end else if (r) begin
      exp_speed = 1;
      exp_cnt   = 0;
    end
    @(negedge clk);
    bus.caught  = 1'b0;
    bus.respawn = 1'b0;
    checks++;
    if (bus.Yball !== 10'd0 || bus.ball_active !== 1'b0)
      begin errors++; $display("FAIL park: got y=%0d act=%0b want y=0 act=0", bus.Yball, bus.ball_active); end
    checks++;
    if (bus.Xball !== exp_x)
      begin errors++; $display("FAIL park_x: got %0d want %0d", bus.Xball, exp_x); end
    checks++;
    if (bus.speed !== 4'(exp_speed))
      begin errors++; $display("FAIL speed_after_decide: got %0d want %0d", bus.speed, exp_speed); end
    repeat (29) tick();
    checks++;
    if (bus.Yball !== 10'd0 || bus.ball_active !== 1'b0)
      begin errors++; $display("FAIL hold_29: got y=%0d act=%0b want y=0 act=0", bus.Yball, bus.ball_active); end
    tick();
    checks++;
    if (bus.Yball !== 10'd0 || bus.ball_active !== 1'b0)
      begin errors++; $display("FAIL hold_to_spawn: got y=%0d act=%0b want y=0 act=0", bus.Yball, bus.ball_active); end
    @(negedge clk);
    predict_spawn_x();
    exp_y = 20;
    checks++;
    if (bus.Xball !== exp_x || bus.Yball !== 10'd20 || bus.ball_active !== 1'b1)
      begin errors++; $display("FAIL respawn: got x=%0d y=%0d act=%0b want x=%0d y=20 act=1", bus.Xball, bus.Yball, bus.ball_active, exp_x); end
  endtask

  task automatic run_descent(input logic c, input logic r);
    bus.caught  = c;
    bus.respawn = r;
    while (exp_y != 455) fall_tick();
    finish_descent(c, r);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.Xball !== 10'd320 || bus.Yball !== 10'd0)
      begin errors++; $display("FAIL reset_pos: got x=%0d y=%0d want x=320 y=0", bus.Xball, bus.Yball); end
    checks++;
    if (bus.ball_active !== 1'b0 || bus.speed !== 4'd1)
      begin errors++; $display("FAIL reset_ctrl: got act=%0b spd=%0d want act=0 spd=1", bus.ball_active, bus.speed); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tick();
    checks++;
    if (bus.Xball !== 10'd320 || bus.Yball !== 10'd0 || bus.ball_active !== 1'b0)
      begin errors++; $display("FAIL idle_stays: got x=%0d y=%0d act=%0b want x=320 y=0 act=0", bus.Xball, bus.Yball, bus.ball_active); end
  endtask

  task automatic test_spawn();
    pulse_new_game();
    checks++;
    if (bus.Yball !== 10'd0 || bus.ball_active !== 1'b0)
      begin errors++; $display("FAIL spawn_state: got y=%0d act=%0b want y=0 act=0", bus.Yball, bus.ball_active); end
    @(negedge clk);
    predict_spawn_x();
    exp_y = 20; exp_speed = 1; exp_cnt = 0;
    checks++;
    if (bus.Yball !== 10'd20 || bus.ball_active !== 1'b1 || bus.speed !== 4'd1)
      begin errors++; $display("FAIL first_fall: got y=%0d act=%0b spd=%0d want y=20 act=1 spd=1", bus.Yball, bus.ball_active, bus.speed); end
    checks++;
    if (bus.Xball !== exp_x || bus.Xball < 10'd64 || bus.Xball > 10'd575)
      begin errors++; $display("FAIL spawn_x: got %0d want %0d", bus.Xball, exp_x); end
  endtask

  task automatic test_descent();
    repeat (434) fall_tick();
    checks++;
    if (bus.Yball !== 10'd454)
      begin errors++; $display("FAIL y_434_ticks: got %0d want 454", bus.Yball); end
    repeat (5) @(negedge clk);
    checks++;
    if (bus.Yball !== 10'd454)
      begin errors++; $display("FAIL y_no_tick: got %0d want 454", bus.Yball); end
    fall_tick();
    checks++;
    if (bus.Yball !== 10'd455 || bus.ball_active !== 1'b1)
      begin errors++; $display("FAIL catch_row: got y=%0d act=%0b want y=455 act=1", bus.Yball, bus.ball_active); end
    finish_descent(1'b0, 1'b0);
  endtask

  task automatic test_speedup();
    repeat (3) run_descent(1'b1, 1'b0);
    checks++;
    if (bus.speed !== 4'd1)
      begin errors++; $display("FAIL speed_3_catches: got %0d want 1", bus.speed); end
    run_descent(1'b1, 1'b0);
    checks++;
    if (bus.speed !== 4'd2)
      begin errors++; $display("FAIL speed_4_catches: got %0d want 2", bus.speed); end
    repeat (4) run_descent(1'b1, 1'b0);
    checks++;
    if (bus.speed !== 4'd3)
      begin errors++; $display("FAIL speed_8_catches: got %0d want 3", bus.speed); end
  endtask

  task automatic test_respawn();
    run_descent(1'b0, 1'b1);
    checks++;
    if (bus.speed !== 4'd1)
      begin errors++; $display("FAIL respawn_resets: got %0d want 1", bus.speed); end
    repeat (4) run_descent(1'b1, 1'b0);
    repeat (3) run_descent(1'b1, 1'b0);
    checks++;
    if (bus.speed !== 4'd2)
      begin errors++; $display("FAIL speed_before_both: got %0d want 2", bus.speed); end
    run_descent(1'b1, 1'b1);
    checks++;
    if (bus.speed !== 4'd3)
      begin errors++; $display("FAIL caught_over_respawn: got %0d want 3", bus.speed); end
    repeat (4) run_descent(1'b1, 1'b0);
    checks++;
    if (bus.speed !== 4'd4)
      begin errors++; $display("FAIL speed_before_win: got %0d want 4", bus.speed); end
  endtask

  task automatic test_win();
    repeat (45) fall_tick();
    checks++;
    if (bus.Yball !== 10'd200)
      begin errors++; $display("FAIL y_before_win: got %0d want 200", bus.Yball); end
    bus.win = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.Yball !== 10'd200 || bus.Xball !== exp_x || bus.ball_active !== 1'b0)
      begin errors++; $display("FAIL frozen: got x=%0d y=%0d act=%0b want x=%0d y=200 act=0", bus.Xball, bus.Yball, bus.ball_active, exp_x); end
    for (int i = 0; i < 10; i++) begin
      repeat (50) tick();
      checks++;
      if (bus.Yball !== 10'd200 || bus.ball_active !== 1'b0)
        begin errors++; $display("FAIL frozen_hold: got y=%0d act=%0b want y=200 act=0", bus.Yball, bus.ball_active); end
    end
    pulse_new_game();
    @(negedge clk);
    checks++;
    if (bus.Yball !== 10'd200 || bus.ball_active !== 1'b0)
      begin errors++; $display("FAIL win_over_new_game: got y=%0d act=%0b want y=200 act=0", bus.Yball, bus.ball_active); end
    bus.win = 1'b0;
    pulse_new_game();
    @(negedge clk);
    predict_spawn_x();
    exp_y = 20; exp_speed = 1; exp_cnt = 0;
    checks++;
    if (bus.Xball !== exp_x || bus.Yball !== 10'd20 || bus.ball_active !== 1'b1 || bus.speed !== 4'd1)
      begin errors++; $display("FAIL unfreeze: got x=%0d y=%0d act=%0b spd=%0d want x=%0d y=20 act=1 spd=1", bus.Xball, bus.Yball, bus.ball_active, bus.speed, exp_x); end
  endtask

  task automatic test_saturate();
    repeat (28) run_descent(1'b1, 1'b0);
    checks++;
    if (bus.speed !== 4'd8)
      begin errors++; $display("FAIL speed_max: got %0d want 8", bus.speed); end
  endtask

  task automatic test_clamp();
    bus.caught = 1'b1;
    repeat (54) fall_tick();
    checks++;
    if (bus.Yball !== 10'd452)
      begin errors++; $display("FAIL y_before_clamp: got %0d want 452", bus.Yball); end
    fall_tick();
    checks++;
    if (bus.Yball !== 10'd455)
      begin errors++; $display("FAIL clamp: got %0d want 455", bus.Yball); end
    finish_descent(1'b1, 1'b0);
    repeat (3) run_descent(1'b1, 1'b0);
    checks++;
    if (bus.speed !== 4'd8)
      begin errors++; $display("FAIL speed_saturates: got %0d want 8", bus.speed); end
  endtask

  task automatic test_restart();
    repeat (10) fall_tick();
    pulse_new_game();
    checks++;
    if (bus.ball_active !== 1'b0)
      begin errors++; $display("FAIL restart_spawn: got act=%0b want act=0", bus.ball_active); end
    @(negedge clk);
    predict_spawn_x();
    exp_y = 20; exp_speed = 1; exp_cnt = 0;
    checks++;
    if (bus.Xball !== exp_x || bus.Yball !== 10'd20 || bus.speed !== 4'd1 || bus.ball_active !== 1'b1)
      begin errors++; $display("FAIL restart_fall: got x=%0d y=%0d spd=%0d act=%0b want x=%0d y=20 spd=1 act=1", bus.Xball, bus.Yball, bus.speed, bus.ball_active, exp_x); end
  endtask

  task automatic test_async_reset();
    repeat (280) fall_tick();
    checks++;
    if (bus.Yball !== 10'd300)
      begin errors++; $display("FAIL y_before_reset: got %0d want 300", bus.Yball); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.Xball !== 10'd320 || bus.Yball !== 10'd0 || bus.ball_active !== 1'b0 || bus.speed !== 4'd1)
      begin errors++; $display("FAIL async_reset: got x=%0d y=%0d act=%0b spd=%0d want x=320 y=0 act=0 spd=1", bus.Xball, bus.Yball, bus.ball_active, bus.speed); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.ball_active !== 1'b0 || bus.Yball !== 10'd0)
        begin errors++; $display("FAIL reset_release: got y=%0d act=%0b want y=0 act=0", bus.Yball, bus.ball_active); end
    end
    pulse_new_game();
    @(negedge clk);
    predict_spawn_x();
    checks++;
    if (bus.Xball !== exp_x || bus.Yball !== 10'd20 || bus.ball_active !== 1'b1 || bus.speed !== 4'd1)
      begin errors++; $display("FAIL post_reset_spawn: got x=%0d y=%0d act=%0b spd=%0d want x=%0d y=20 act=1 spd=1", bus.Xball, bus.Yball, bus.ball_active, bus.speed, exp_x); end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.new_game   = 1'b0;
    bus.respawn    = 1'b0;
    bus.caught     = 1'b0;
    bus.win        = 1'b0;
    exp_y          = 0;
    exp_speed      = 1;
    exp_cnt        = 0;
    exp_x          = 10'd320;
    test_reset();
    test_spawn();
    test_descent();
    test_speedup();
    test_respawn();
    test_win();
    test_saturate();
    test_clamp();
    test_restart();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
